// File: rtl/dmem_access_unit.sv
// dmem_access_unit: executes one load/store command against a word-addressed
// data memory over a req/ack handshake with a timeout. Stores are aligned and
// byte-enabled. Load data is extracted, then sign- or zero-extended. Exactly
// one response is returned per accepted command.
module dmem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [4:0] OP_LB  = 5'b01010;
    localparam logic [4:0] OP_LH  = 5'b01011;
    localparam logic [4:0] OP_LW  = 5'b01100;
    localparam logic [4:0] OP_LBU = 5'b01101;
    localparam logic [4:0] OP_LHU = 5'b01110;
    localparam logic [4:0] OP_SB  = 5'b01111;
    localparam logic [4:0] OP_SH  = 5'b10000;
    localparam logic [4:0] OP_SW  = 5'b10001;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    state_e          state;
    state_e          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [4:0]      op_q;
    logic [1:0]      off_q;

    logic            cmd_fire;
    logic            cmd_ok;
    logic            cmd_legal;
    logic            cmd_misaligned;
    logic            cmd_store;
    logic [3:0]      fmt_be;
    logic [31:0]     fmt_wdata;
    logic            timeout_hit;
    logic            op_is_load;
    logic [31:0]     shifted;
    logic [31:0]     load_data;

    // cmd_ready is registered, so it stays low during reset and rises one cycle after release.
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign cmd_ok      = cmd_legal & ~cmd_misaligned;
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
    assign op_is_load  = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW) ||
                         (op_q == OP_LBU) || (op_q == OP_LHU);

    // Decode the incoming command: legality, alignment and store lane formatting.
    always_comb begin
        // NOTE: every signal gets a default first, so no path holds a stale value and no latch is inferred.
        cmd_legal      = 1'b1;
        cmd_misaligned = 1'b0;
        cmd_store      = 1'b0;
        fmt_be         = 4'b1111;
        fmt_wdata      = cmd_wdata;
        case (cmd_op)
            OP_LB, OP_LBU: ;
            OP_LH, OP_LHU: cmd_misaligned = cmd_addr[0];
            OP_LW:         cmd_misaligned = |cmd_addr[1:0];
            OP_SB: begin
                cmd_store = 1'b1;
                fmt_be    = 4'b0001 << cmd_addr[1:0];
                fmt_wdata = {4{cmd_wdata[7:0]}};
            end
            OP_SH: begin
                cmd_store      = 1'b1;
                cmd_misaligned = cmd_addr[0];
                fmt_be         = cmd_addr[1] ? 4'b1100 : 4'b0011;
                fmt_wdata      = {2{cmd_wdata[15:0]}};
            end
            OP_SW: begin
                cmd_store      = 1'b1;
                cmd_misaligned = |cmd_addr[1:0];
            end
            default: cmd_legal = 1'b0;
        endcase
    end

    // Extract the addressed byte/half/word from the returned memory word and extend it.
    always_comb begin
        shifted   = mem_rdata >> {off_q, 3'b000};
        load_data = shifted;
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state logic. A late ack wins over the timeout in the final cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = cmd_ok ? ACCESS : RESP;
            ACCESS:  if (mem_ack || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Timeout counter: counts unacknowledged ACCESS cycles and sits at zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              to_cnt <= '0;
        else if (state == ACCESS && !mem_ack) to_cnt <= to_cnt + 1'b1;
        else                                  to_cnt <= '0;
    end

    // Registered outputs and the latched command, all driven from the next-state decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            op_q      <= '0;
            off_q     <= '0;
        end else begin
            cmd_ready <= (state_nxt == IDLE);
            mem_req   <= (state_nxt == ACCESS);
            rsp_valid <= (state_nxt == RESP);
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (state == IDLE && cmd_fire) begin
                op_q      <= cmd_op;
                off_q     <= cmd_addr[1:0];
                mem_we    <= cmd_store;
                mem_be    <= fmt_be;
                mem_addr  <= {cmd_addr[31:2], 2'b00};
                mem_wdata <= fmt_wdata;
                rsp_err   <= ~cmd_ok;
            end
            if (state == ACCESS) begin
                if (mem_ack)          rsp_rdata <= op_is_load ? load_data : 32'h0;
                else if (timeout_hit) rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Responder side of the core's load/store command path: consumes the 5-bit load/store op codes and MemRW-style intent that the decoder produces, and runs the data-memory transaction.
- Aligns and byte-enables stores, then extracts and sign- or zero-extends load data.
- Talks to a word-addressed data memory over a req/ack handshake with a timeout, and returns one response per accepted command.

Parameters:
- TIMEOUT, 255: maximum cycles mem_req is held without mem_ack before aborting with error; must be ≥1.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command (IDLE only)
- cmd_op  in  5  01010 LB, 01011 LH, 01100 LW, 01101 LBU, 01110 LHU, 01111 SB, 10000 SH, 10001 SW
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal op or timeout
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  1 = write, 0 = read
- mem_be  out  4  byte enables (writes); 4'b1111 on reads
- mem_addr  out  32  word address, bits [1:0] always 00
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completed (read data valid same cycle)
- mem_rdata  in  32  read word

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high on rst.
- Reset: state IDLE; all outputs 0, cmd_ready included; the timeout counter and latched command are cleared. Reset mid-transaction drops mem_req immediately and produces no response. cmd_ready rises in the first cycle after rst deasserts.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - cmd_ready=1; handshake completes on cmd_valid & cmd_ready at a rising edge, which latches op, addr and wdata.
  - Illegal op (any code not listed) → RESP with rsp_err=1 and no memory access.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) → same as illegal op.
  - Otherwise → ACCESS.
- ACCESS:
  - mem_req=1. mem_we, mem_be, mem_addr and mem_wdata are registered and stable for the whole request.
  - Timeout counter starts at 0 and increments each ACCESS cycle with mem_ack=0.
  - mem_ack=1 → RESP. Loads capture mem_rdata that cycle.
  - Counter reaches TIMEOUT-1 with no ack → RESP with rsp_err=1 and rsp_rdata=0. mem_req is therefore high exactly TIMEOUT cycles.
  - mem_ack in the same cycle as the last timeout cycle counts as success.
- RESP:
  - rsp_valid=1 for exactly one cycle, with no backpressure; mem_req=0.
  - Next state IDLE; rsp_valid, rsp_rdata and rsp_err return to 0.
- Latency:
  - Error response: rsp_valid in the cycle after acceptance.
  - Normal access: mem_req starts the cycle after acceptance; rsp_valid follows the cycle after mem_ack.
  - Minimum normal latency is 2 cycles; a new command can be accepted no earlier than the cycle after RESP.
- mem_ack outside ACCESS is ignored.
- Store formatting (mem_addr={addr[31:2],2'b00}):
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- Load extraction: shifted = mem_rdata >> (8*addr[1:0]).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: whole word.

Test Plan:
1. SW addr 0x100, wdata 0xDEADBEEF, mem_ack 2 cycles after mem_req rises → mem_req high exactly 2 cycles with we=1, be=1111, addr 0x100, wdata 0xDEADBEEF; then rsp_valid=1 for one cycle with rsp_err=0 and rsp_rdata=0.
2. mem_rdata=0x80FF1234 with immediate ack:
   - LB 0x103 → 0xFFFFFF80; LBU 0x103 → 0x00000080.
   - LH 0x102 → 0xFFFF80FF; LHU 0x102 → 0x000080FF.
   - LW 0x100 → 0x80FF1234.
   - Each has mem_be=1111, mem_addr=0x100 and response 2 cycles after acceptance.
3. SB addr 0x201, wdata 0x000000A5 → be=0010, wdata 0xA5A5A5A5, mem_addr 0x200. SH addr 0x202, wdata 0x0000ABCD → be=1100, wdata 0xABCDABCD.
4. Errors with no mem_req ever asserted, rsp_valid=1 and rsp_err=1 in the cycle after acceptance:
   - LW addr 0x101
   - SH addr 0x003
   - op 00000
5. TIMEOUT=4, LW 0x40, mem_ack held 0 → mem_req high exactly 4 cycles, then rsp_err=1 and rsp_rdata=0. Repeat with ack on the 4th cycle → rsp_err=0 and data returned.
6. Async rst pulse mid-ACCESS → mem_req and all outputs drop to 0 immediately with no rsp_valid. After release, cmd_ready=1 and a following SW completes normally; a stray mem_ack while IDLE produces no response.
